// File: rtl/fetch_pred_pc_pkg.sv
// Shared encodings and widths for the fetch-stage PC prediction slice.
// Instruction codes follow the Y86-64 numbering used by the rest of the pipeline.
package fetch_pred_pc_pkg;

    localparam int ICODE_W = 4;
    localparam int ADDR_W  = 64;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 64'h0;

    typedef enum logic [ICODE_W-1:0] {
        ICODE_HALT   = 4'h0,
        ICODE_NOP    = 4'h1,
        ICODE_RRMOVQ = 4'h2,
        ICODE_IRMOVQ = 4'h3,
        ICODE_RMMOVQ = 4'h4,
        ICODE_MRMOVQ = 4'h5,
        ICODE_OPQ    = 4'h6,
        ICODE_JXX    = 4'h7,
        ICODE_CALL   = 4'h8,
        ICODE_RET    = 4'h9,
        ICODE_PUSHQ  = 4'hA,
        ICODE_POPQ   = 4'hB
    } icode_e;

    // Always-taken policy: jumps and calls go to valC, everything else
    // (including RET and illegal codes) falls through to valP.
    function automatic logic [ADDR_W-1:0] predict_pc(
        input logic [ICODE_W-1:0] icode,
        input logic [ADDR_W-1:0]  val_c,
        input logic [ADDR_W-1:0]  val_p
    );
        if (icode == ICODE_JXX || icode == ICODE_CALL) begin
            return val_c;
        end
        return val_p;
    endfunction

endpackage

// File: rtl/fetch_pred_pc_if.sv
// Signal bundle between fetch/pipeline-control logic and the PC predictor.
// master drives fetch and stage information; slave is the predictor itself.
interface fetch_pred_pc_if
    import fetch_pred_pc_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic               F_stall_i;
    logic [ICODE_W-1:0] f_icode_i;
    logic [ADDR_W-1:0]  f_valC_i;
    logic [ADDR_W-1:0]  f_valP_i;
    logic [ICODE_W-1:0] M_icode_i;
    logic               M_Cnd_i;
    logic [ICODE_W-1:0] W_icode_i;
    logic               cnt_clr_i;
    logic [ADDR_W-1:0]  F_predPC_o;
    logic [ADDR_W-1:0]  f_predPC_o;
    logic               f_redirect_o;
    logic [CNT_W-1:0]   mispred_cnt_o;
    logic [CNT_W-1:0]   ret_cnt_o;

    modport master (
        output F_stall_i, f_icode_i, f_valC_i, f_valP_i,
               M_icode_i, M_Cnd_i, W_icode_i, cnt_clr_i,
        input  F_predPC_o, f_predPC_o, f_redirect_o,
               mispred_cnt_o, ret_cnt_o
    );

    modport slave (
        input  F_stall_i, f_icode_i, f_valC_i, f_valP_i,
               M_icode_i, M_Cnd_i, W_icode_i, cnt_clr_i,
        output F_predPC_o, f_predPC_o, f_redirect_o,
               mispred_cnt_o, ret_cnt_o
    );

endinterface

// File: rtl/fetch_pred_pc_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module fetch_pred_pc_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_next = count_reg + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fetch_pred_pc.sv
// Fetch-stage F register with always-taken next-PC prediction, redirect flag
// and saturating counters for mispredict / RET correction events.
module fetch_pred_pc
    import fetch_pred_pc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                CNT_W    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_pred_pc_if.slave bus
);

    localparam int NUM_CNT = 2;

    logic [ADDR_W-1:0] f_predpc_next;
    logic [ADDR_W-1:0] f_predpc_reg;
    logic              mispredict;
    logic              retw;
    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];

    assign f_predpc_next = predict_pc(bus.f_icode_i, bus.f_valC_i, bus.f_valP_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f_predpc_reg <= RESET_PC;
        end else if (!bus.F_stall_i) begin
            f_predpc_reg <= f_predpc_next;
        end
    end

    assign mispredict = (bus.M_icode_i == ICODE_JXX) && !bus.M_Cnd_i;
    assign retw       = (bus.W_icode_i == ICODE_RET);

    // Index 0 counts M-stage mispredicts, index 1 counts W-stage returns.
    assign cnt_inc = {retw, mispredict};

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            fetch_pred_pc_sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .clr   (bus.cnt_clr_i),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign bus.F_predPC_o    = f_predpc_reg;
    assign bus.f_predPC_o    = f_predpc_next;
    assign bus.f_redirect_o  = mispredict | retw;
    assign bus.mispred_cnt_o = cnt_val[0];
    assign bus.ret_cnt_o     = cnt_val[1];

endmodule

// File: doc/fetch_pred_pc.md
Name: fetch_pred_pc

Overview:
- Producer side of the fetch-stage PC selection. Holds the F pipeline register (F_predPC), computes the next predicted PC from the instruction just fetched, and supplies F_predPC to the PC-selection mux.
- Also owns the fetch-side redirect bookkeeping. It flags when the selected PC came from a correction path (mispredicted JXX or RET), and it keeps saturating event counters for those corrections, readable by debug/perf logic.
- Sits between the instruction-memory/split/align logic (f_icode, f_valC, f_valP) and the PC-selection mux. It is controlled by pipeline control (F_stall).

Parameters:
- RESET_PC, 64'h0, value loaded into F_predPC on reset.
- CNT_W, 32, width of each event counter.

Ports:
- clk_i  in  1  clock, all state updates on its rising edge
- rst_i  in  1  synchronous active-high reset
- F_stall_i  in  1  pipeline control: hold F register this cycle
- f_icode_i  in  `ICODE_BUS  icode of the instruction fetched this cycle
- f_valC_i  in  `ADDR_BUS  constant word of the fetched instruction (jump/call target)
- f_valP_i  in  `ADDR_BUS  address of the next sequential instruction
- M_icode_i  in  `ICODE_BUS  icode in memory stage
- M_Cnd_i  in  1  branch condition of the memory-stage instruction
- W_icode_i  in  `ICODE_BUS  icode in write-back stage
- cnt_clr_i  in  1  synchronous clear of both event counters
- F_predPC_o  out  `ADDR_BUS  registered predicted PC, to the PC-selection mux
- f_predPC_o  out  `ADDR_BUS  combinational next prediction (debug)
- f_redirect_o  out  1  combinational: the PC selected this cycle is a correction (M mispredict or W RET)
- mispred_cnt_o  out  CNT_W  number of cycles with a mispredicted JXX in M
- ret_cnt_o  out  CNT_W  number of cycles with a RET in W

Behaviour:
- Prediction (combinational): f_predPC = f_valC_i when f_icode_i is `JXX or `CALL; otherwise f_valP_i. Always-taken policy; RET is predicted as f_valP_i and fixed later by the mux.
- F register:
  - rst_i=1: F_predPC_o <= RESET_PC.
  - Else if F_stall_i=1: hold.
  - Else: F_predPC_o <= f_predPC.
  - Latency from fetch to F_predPC_o is 1 cycle.
- Redirect flag:
  - mispredict = (M_icode_i==`JXX && !M_Cnd_i).
  - retw = (W_icode_i==`RET).
  - f_redirect_o = mispredict | retw. Priority matches the selection mux (mispredict first), but the flag is a plain OR.
- Counters:
  - rst_i or cnt_clr_i: both counters go to 0. rst_i has priority; cnt_clr_i overrides an increment in the same cycle.
  - mispred_cnt increments by 1 on each cycle mispredict=1. ret_cnt increments by 1 on each cycle retw=1.
  - Both can increment in the same cycle.
  - Each saturates at all-ones (2^CNT_W-1) and never wraps.
  - Counters advance regardless of F_stall_i; they count stage occupancy cycles, not unique instructions.
- Reset values: F_predPC_o=RESET_PC, mispred_cnt_o=0, ret_cnt_o=0. Combinational outputs follow their inputs during reset.
- Reset mid-operation: any pending stall or count state is discarded, and F_predPC_o=RESET_PC on the next cycle.
- Unknown or illegal f_icode values take the default path (f_valP_i). No error is raised here; the status logic handles it.

Decomposition:
- Shared package/define file: ICODE encodings (`JXX, `CALL, `RET, ...), `ICODE_BUS and `ADDR_BUS widths.
- A RESET_PC default may be added there as a constant.
- One natural sub-module: sat_counter (parameter W; inputs clk_i, rst_i, clr, inc; output count). It is instantiated twice.

Test Plan:
- Reset, RESET_PC=64'h100: assert rst_i for 2 cycles -> F_predPC_o=64'h100, both counters 0.
- Sequential: f_icode=OPQ, f_valP=64'h10A, no stall -> next cycle F_predPC_o=64'h10A.
- Jump/call: f_icode=`JXX, f_valC=64'h200, f_valP=64'h109 -> F_predPC_o=64'h200. Same with `CALL, f_valC=64'h300 -> 64'h300.
- Stall: F_predPC_o=64'h200, F_stall_i=1 for 3 cycles with f_valP changing -> F_predPC_o stays 64'h200. Release -> takes the new prediction 1 cycle later.
- Counters: M_icode=`JXX, M_Cnd=0 for 4 cycles, with W_icode=`RET in 2 of them -> mispred_cnt=4, ret_cnt=2, and f_redirect_o=1 in exactly those 4 cycles. Same pattern with M_Cnd=1 -> no mispredict counts.
- Saturation/clear:
  - CNT_W=3: apply 10 mispredict cycles -> mispred_cnt=7 held.
  - cnt_clr_i=1 together with mispredict=1 -> counter=0.
  - rst_i while stalled -> F_predPC_o=RESET_PC next cycle.
